typed_ndata_arbiter: RTL

Packet-granular N-to-1 arbiter for typed_ndata streams. It selects an input autonomously by round-robin, so no external select stream is needed. The chosen input holds the output until its `last` beat. The block drives a registered output and emits one index record per granted packet on a side stream, which a downstream demultiplexer uses to route responses. It sits between parallel producer pipelines and a shared consumer, for example a shared writer or serialiser.

---
 rtl/typed_ndata_arbiter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/typed_ndata_arbiter.sv
// Packet-granular N-to-1 round-robin arbiter with registered output and a grant-index side FIFO.
// Define TYPED_NDATA_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module typed_ndata_arbiter #(
    parameter int DATABEAT_SIZE  = 64,
    parameter int NUM_STREAMS    = 4,
    parameter int SEL_FIFO_DEPTH = 4,
    parameter int TYP_WIDTH      = 4,
    localparam int IDX_W         = $clog2(NUM_STREAMS)
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic [NUM_STREAMS-1:0][DATABEAT_SIZE*8-1:0]   in_data,
    input  logic [NUM_STREAMS-1:0][TYP_WIDTH-1:0]         in_typ,
    input  logic [NUM_STREAMS-1:0][DATABEAT_SIZE-1:0]     in_keep,
    input  logic [NUM_STREAMS-1:0]                        in_last,
    input  logic [NUM_STREAMS-1:0]                        in_valid,
    output logic [NUM_STREAMS-1:0]                        in_ready,
    output logic [DATABEAT_SIZE*8-1:0]                    out_data,
    output logic [TYP_WIDTH-1:0]                          out_typ,
    output logic [DATABEAT_SIZE-1:0]                      out_keep,
    output logic                                          out_last,
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic [IDX_W-1:0]                              sel_out_data,
    output logic                                          sel_out_valid,
    input  logic                                          sel_out_ready
);
    localparam int PTR_W = $clog2(SEL_FIFO_DEPTH);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t           state_reg, state_next;
    logic [IDX_W-1:0] grant_reg;
    logic [IDX_W-1:0] winner;
    logic             any_req;
    logic             stage_ready;
    logic             ready_en;
    logic             push, pop, load;
    logic             fifo_full, fifo_empty;
    logic [PTR_W:0]   wr_ptr_reg, rd_ptr_reg;
    logic [IDX_W-1:0] fifo_mem [SEL_FIFO_DEPTH];

    assign any_req     = |in_valid;
    assign stage_ready = !out_valid || out_ready;
    assign pop         = sel_out_valid && sel_out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept a grant.
    assign push        = (state_reg == IDLE) && any_req && (!fifo_full || pop);
    assign load        = (state_reg == LOCKED) && in_valid[grant_reg] && stage_ready;

`ifdef TYPED_NDATA_ARB_FIXED_PRIO_EN
    always_comb begin
        winner = '0;
        for (int i = NUM_STREAMS - 1; i >= 0; i--) begin
            if (in_valid[IDX_W'(i)]) winner = IDX_W'(i);
        end
    end
`else
    logic [IDX_W-1:0] rr_ptr_reg;
    logic [IDX_W-1:0] rr_idx;
    logic             rr_found;

    // Search starts one past the last winner and wraps around all streams.
    always_comb begin
        winner   = '0;
        rr_idx   = '0;
        rr_found = 1'b0;
        for (int k = 1; k <= NUM_STREAMS; k++) begin
            rr_idx = IDX_W'((int'(rr_ptr_reg) + k) % NUM_STREAMS);
            if (!rr_found && in_valid[rr_idx]) begin
                winner   = rr_idx;
                rr_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) rr_ptr_reg <= IDX_W'(NUM_STREAMS - 1);
        else if (push) rr_ptr_reg <= winner;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            grant_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (push) grant_reg <= winner;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (push) state_next = LOCKED;
            LOCKED:  if (load && in_last[grant_reg]) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ready_en = (state_reg == LOCKED) && stage_ready;
    end

    for (genvar gi = 0; gi < NUM_STREAMS; gi++) begin : g_ready
        assign in_ready[gi] = ready_en && (grant_reg == IDX_W'(gi));
    end

    always_ff @(posedge clk) begin
        if (rst) out_valid <= 1'b0;
        else if (load) out_valid <= 1'b1;
        else if (out_ready) out_valid <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (load) begin
            out_data <= in_data[grant_reg];
            out_typ  <= in_typ[grant_reg];
            out_keep <= in_keep[grant_reg];
            out_last <= in_last[grant_reg];
        end
    end

    // Pointers carry one extra wrap bit to tell full from empty.
    assign fifo_empty    = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full     = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                           (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);
    assign sel_out_valid = !fifo_empty;
    assign sel_out_data  = fifo_mem[rd_ptr_reg[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_reg[PTR_W-1:0]] <= winner;
    end
endmodule
